// File: rtl/c16_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : c16_muldiv
// Description : Iterative radix-2 multiply/divide unit for the c16 core.
//               Shift-add multiply and restoring divide, both on operand
//               magnitudes, with a final sign-fix cycle. Fixed latency of
//               WIDTH+2 cycles from start to done for every operation.
// Revision    : 1.0 - initial release
// ============================================================================
module c16_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int               c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_q;    // product sign (mul) or quotient sign (div)
    logic               r_neg_r;    // remainder sign: follows the dividend
    logic               r_div0;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   r_a_orig;   // raw dividend, returned on divide-by-zero
    logic [2*WIDTH-1:0] r_acc;      // {hi,lo} working register
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;

    // Operand magnitudes; sign bits only count for the signed ops (op[0]=1).
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_accept;

    assign w_a_neg  = op[0] & a[WIDTH-1];
    assign w_b_neg  = op[0] & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // A new request is only taken when the unit is not busy.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Multiply step: conditionally add the multiplicand into the upper half,
    // keep the carry, then shift the whole accumulator right by one.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: the shifted partial remainder needs one extra bit, so the
    // trial subtraction is WIDTH+1 wide and its MSB is the borrow.
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_div_next = w_trial[WIDTH]
                      ? {r_acc[2*WIDTH-2:0], 1'b0}
                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign correction of the finished magnitude result.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_fix_hi;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Select the final lo/hi pair, including the divide-by-zero override.
    always_comb begin
        w_fix_lo = w_prod[WIDTH-1:0];
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_lo = c_ONES;
                w_fix_hi = r_a_orig;
            end else begin
                w_fix_lo = w_quot;
                w_fix_hi = w_rem;
            end
        end
    end

    // Datapath: latch operands on accept, otherwise iterate while in CALC.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opnd   <= '0;
            r_a_orig <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (b == '0);
            r_a_orig <= a;
            // mul: multiplier in the low half, multiplicand held aside;
            // div: dividend in the low half, divisor held aside.
            r_opnd   <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
        end else if (r_state == S_CALC) begin
            r_cnt    <= r_cnt + c_CW'(1);
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= w_fix_lo;
                    r_hi    <= w_fix_hi;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign lo   = r_lo;
    assign hi   = r_hi;

endmodule
`default_nettype wire

// File: tb/tb_c16_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_c16_muldiv
// Description : Self-checking bench for c16_muldiv at WIDTH = 8, 16 and 32.
//               Directed cases plus random operands against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c16_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic        start8,  busy8,  done8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, lo8, hi8;

    logic        start16, busy16, done16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, lo16, hi16;

    logic        start32, busy32, done32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, lo32, hi32;

    c16_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .lo(lo8), .hi(hi8)
    );

    c16_muldiv #(.WIDTH(16)) u_dut16 (
        .clk(clk), .resetn(resetn), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .lo(lo16), .hi(hi16)
    );

    c16_muldiv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .lo(lo32), .hi(hi32)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference model: plain integer arithmetic on sign-extended values.
    function automatic void model(input int w, input logic [1:0] o,
                                  input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] elo, output logic [63:0] ehi);
        logic [63:0] m;
        logic [63:0] p;
        longint      sa, sb, sp, q, r, most_neg;
        m        = mask_of(w);
        sa       = av[w-1] ? (longint'(av) - (longint'(1) << w)) : longint'(av);
        sb       = bv[w-1] ? (longint'(bv) - (longint'(1) << w)) : longint'(bv);
        most_neg = -(longint'(1) << (w - 1));
        elo      = '0;
        ehi      = '0;
        case (o)
            2'b00: begin
                p   = av * bv;
                elo = p & m;
                ehi = (p >> w) & m;
            end
            2'b01: begin
                sp  = sa * sb;
                p   = 64'(sp);
                elo = p & m;
                ehi = (p >> w) & m;
            end
            2'b10: begin
                if (bv == 64'd0) begin
                    elo = m;
                    ehi = av;
                end else begin
                    elo = av / bv;
                    ehi = av % bv;
                end
            end
            default: begin
                if (bv == 64'd0) begin
                    elo = m;
                    ehi = av;
                end else if (sa == most_neg && sb == -1) begin
                    elo = av;
                    ehi = 64'd0;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    elo = 64'(q) & m;
                    ehi = 64'(r) & m;
                end
            end
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            8:       return busy8;
            16:      return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic logic [63:0] get_lo(input int w);
        case (w)
            8:       return 64'(lo8);
            16:      return 64'(lo16);
            default: return 64'(lo32);
        endcase
    endfunction

    function automatic logic [63:0] get_hi(input int w);
        case (w)
            8:       return 64'(hi8);
            16:      return 64'(hi16);
            default: return 64'(hi32);
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic [1:0] o,
                         input logic [63:0] av, input logic [63:0] bv);
        case (w)
            8:       begin start8  = st; op8  = o; a8  = av[7:0];  b8  = bv[7:0];  end
            16:      begin start16 = st; op16 = o; a16 = av[15:0]; b16 = bv[15:0]; end
            default: begin start32 = st; op32 = o; a32 = av[31:0]; b32 = bv[31:0]; end
        endcase
    endtask

    // One operation: lat counts posedges from the one sampling start up to
    // and including the one after which done is visible.
    task automatic run_op(input int w, input logic [1:0] o,
                          input logic [63:0] av, input logic [63:0] bv,
                          output logic [63:0] rlo, output logic [63:0] rhi,
                          output int lat, output int busyc);
        @(negedge clk);
        drive(w, 1'b1, o, av, bv);
        @(posedge clk);
        #1;
        drive(w, 1'b0, o, av, bv);
        lat   = 1;
        busyc = get_busy(w) ? 1 : 0;
        while (!get_done(w) && lat < 4 * w + 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (get_busy(w)) busyc++;
        end
        rlo = get_lo(w);
        rhi = get_hi(w);
    endtask

    task automatic directed16(input string tag, input logic [1:0] o,
                              input logic [63:0] av, input logic [63:0] bv,
                              input logic [63:0] elo, input logic [63:0] ehi);
        logic [63:0] rlo, rhi;
        int          lat, busyc;
        run_op(16, o, av, bv, rlo, rhi, lat, busyc);
        check({tag, "_lo"}, rlo, elo);
        check({tag, "_hi"}, rhi, ehi);
        check({tag, "_lat"}, 64'(lat), 64'd18);
    endtask

    task automatic rand_runs(input int w, input int n);
        logic [63:0] m, av, bv, elo, ehi, rlo, rhi;
        logic [1:0]  o;
        int          lat, busyc, sel;
        m = mask_of(w);
        for (int i = 0; i < n; i++) begin
            o   = 2'($urandom_range(0, 3));
            av  = {$urandom, $urandom} & m;
            bv  = {$urandom, $urandom} & m;
            sel = $urandom_range(0, 15);
            if (sel == 0) bv = 64'd0;
            if (sel == 1) begin av = 64'd1 << (w - 1); bv = m; end
            if (sel == 2) av = 64'd1 << (w - 1);
            if (sel == 3) bv = 64'd1 << (w - 1);
            run_op(w, o, av, bv, rlo, rhi, lat, busyc);
            model(w, o, av, bv, elo, ehi);
            check($sformatf("w%0d_op%0d_lo", w, o), rlo, elo);
            check($sformatf("w%0d_op%0d_hi", w, o), rhi, ehi);
            check($sformatf("w%0d_lat", w), 64'(lat), 64'(w + 2));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rlo, rhi;
        int          lat, busyc, extra;

        resetn = 1'b0;
        drive(8,  1'b0, 2'b00, 64'd0, 64'd0);
        drive(16, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(32, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy16), 64'd0);
        check("rst_done", 64'(done16), 64'd0);
        check("rst_lo",   64'(lo16),   64'd0);
        check("rst_hi",   64'(hi16),   64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Unsigned full-scale multiply with latency and busy length.
        run_op(16, 2'b00, 64'hFFFF, 64'hFFFF, rlo, rhi, lat, busyc);
        check("umul_ff_lo",   rlo, 64'h0001);
        check("umul_ff_hi",   rhi, 64'hFFFE);
        check("umul_ff_lat",  64'(lat), 64'd18);
        check("umul_ff_busy", 64'(busyc), 64'd17);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done16), 64'd0);

        directed16("smul_m3x5",   2'b01, 64'hFFFD, 64'h0005, 64'hFFF1, 64'hFFFF);
        directed16("smul_minmin", 2'b01, 64'h8000, 64'h8000, 64'h0000, 64'h4000);
        directed16("sdiv_m7d2",   2'b11, 64'hFFF9, 64'h0002, 64'hFFFD, 64'hFFFF);
        directed16("udiv_100d7",  2'b10, 64'd100,  64'd7,    64'd14,   64'd2);
        directed16("udiv_zero",   2'b10, 64'h1234, 64'h0000, 64'hFFFF, 64'h1234);
        directed16("sdiv_ovf",    2'b11, 64'h8000, 64'hFFFF, 64'h8000, 64'h0000);
        directed16("umul_b0",     2'b00, 64'h1234, 64'h0000, 64'h0000, 64'h0000);

        // Start issued during the done cycle is accepted.
        check("in_done_cycle", 64'(done16), 64'd1);
        directed16("b2b_smul", 2'b01, 64'h0007, 64'hFFFE, 64'hFFF2, 64'hFFFF);

        // A start during busy is dropped and its operands ignored.
        @(negedge clk);
        drive(16, 1'b1, 2'b00, 64'd3, 64'd5);
        @(posedge clk);
        #1;
        drive(16, 1'b0, 2'b00, 64'd3, 64'd5);
        lat = 1;
        while (!done16 && lat < 60) begin
            if (lat == 5) begin
                @(negedge clk);
                drive(16, 1'b1, 2'b10, 64'd7, 64'd9);
            end
            @(posedge clk);
            #1;
            drive(16, 1'b0, 2'b10, 64'd7, 64'd9);
            lat++;
        end
        check("drop_lo",  64'(lo16), 64'd15);
        check("drop_hi",  64'(hi16), 64'd0);
        check("drop_lat", 64'(lat),  64'd18);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done16) extra++;
        end
        check("drop_no_second_done", 64'(extra), 64'd0);

        // Reset in the middle of an operation abandons it.
        @(negedge clk);
        drive(16, 1'b1, 2'b01, 64'h0123, 64'h0045);
        @(posedge clk);
        #1;
        drive(16, 1'b0, 2'b01, 64'h0123, 64'h0045);
        repeat (7) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy16), 64'd0);
        check("midrst_done", 64'(done16), 64'd0);
        check("midrst_lo",   64'(lo16),   64'd0);
        check("midrst_hi",   64'(hi16),   64'd0);
        @(negedge clk);
        resetn = 1'b1;
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done16) extra++;
        end
        check("midrst_no_done", 64'(extra), 64'd0);

        // Randomised operands against the reference model at each width.
        rand_runs(8, 1000);
        rand_runs(16, 300);
        rand_runs(32, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
